// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and load paths with a pending-write scoreboard.
// Grants are registered; hazards are read combinationally from the registered scoreboard.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_addr,
    input  logic [31:0] alu_wb_data,
    output logic        alu_wb_ack,
    input  logic        mem_wb_valid,
    input  logic [4:0]  mem_wb_addr,
    input  logic [31:0] mem_wb_data,
    output logic        mem_wb_ack,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  chk_addr_a,
    input  logic [4:0]  chk_addr_b,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic        reg_wr_en,
    output logic [4:0]  reg_wr_addr,
    output logic [31:0] reg_wr_data,
    output logic [31:0] pending
);

    logic        alu_elig_s;
    logic        mem_elig_s;
    logic        grant_alu_s;
    logic        grant_mem_s;
    logic        grant_s;
    logic [4:0]  grant_addr_s;
    logic [31:0] grant_data_s;
    logic [31:0] pending_next_s;
    logic        alu_first_r;

    // A requester whose ack is high this cycle is being consumed and must not be re-granted.
    always_comb begin
        alu_elig_s  = alu_wb_valid & ~alu_wb_ack;
        mem_elig_s  = mem_wb_valid & ~mem_wb_ack;
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (alu_elig_s && mem_elig_s) begin
            grant_alu_s = alu_first_r;
            grant_mem_s = ~alu_first_r;
        end else begin
            grant_alu_s = alu_elig_s;
            grant_mem_s = mem_elig_s;
        end
        grant_s      = grant_alu_s | grant_mem_s;
        grant_addr_s = grant_alu_s ? alu_wb_addr : mem_wb_addr;
        grant_data_s = grant_alu_s ? alu_wb_data : mem_wb_data;
    end

    // Scoreboard update: clear on writeback first, so a same-edge reservation wins.
    always_comb begin
        pending_next_s = pending;
        if (grant_s && (grant_addr_s != 5'd0)) begin
            pending_next_s[grant_addr_s] = 1'b0;
        end else begin
            pending_next_s[0] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != 5'd0)) begin
            pending_next_s[rsv_addr] = 1'b1;
        end else begin
            pending_next_s[0] = 1'b0;
        end
        pending_next_s[0] = 1'b0;
    end

    // Registered grant, write port, round-robin pointer and scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_wb_ack  <= 1'b0;
            mem_wb_ack  <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 5'd0;
            reg_wr_data <= 32'd0;
            pending     <= 32'd0;
            alu_first_r <= 1'b1;
        end else begin
            alu_wb_ack <= grant_alu_s;
            mem_wb_ack <= grant_mem_s;
            reg_wr_en  <= grant_s & (grant_addr_s != 5'd0);
            pending    <= pending_next_s;
            if (grant_s) begin
                reg_wr_addr <= grant_addr_s;
                reg_wr_data <= grant_data_s;
                alu_first_r <= grant_mem_s;
            end else begin
                reg_wr_addr <= reg_wr_addr;
                reg_wr_data <= reg_wr_data;
                alu_first_r <= alu_first_r;
            end
        end
    end

    assign hazard_a = pending[chk_addr_a];
    assign hazard_b = pending[chk_addr_b];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a cycle-level reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_wb_valid = 1'b0;
    logic [4:0]  alu_wb_addr = 5'd0;
    logic [31:0] alu_wb_data = 32'd0;
    logic        alu_wb_ack;
    logic        mem_wb_valid = 1'b0;
    logic [4:0]  mem_wb_addr = 5'd0;
    logic [31:0] mem_wb_data = 32'd0;
    logic        mem_wb_ack;
    logic        rsv_valid = 1'b0;
    logic [4:0]  rsv_addr = 5'd0;
    logic [4:0]  chk_addr_a = 5'd0;
    logic [4:0]  chk_addr_b = 5'd0;
    logic        hazard_a;
    logic        hazard_b;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] pending;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, in spec terms
    bit          m_pend [32];
    bit          m_alu_ack, m_mem_ack, m_wr_en;
    bit [4:0]    m_wr_addr;
    bit [31:0]   m_wr_data;
    string       m_last_winner;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .alu_wb_ack(alu_wb_ack),
        .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
        .mem_wb_ack(mem_wb_ack),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] pend_word();
        bit [31:0] w = 32'd0;
        for (int i = 1; i < 32; i++) w[i] = m_pend[i];
        return w;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_alu_ack = 1'b0; m_mem_ack = 1'b0; m_wr_en = 1'b0;
        m_wr_addr = 5'd0; m_wr_data = 32'd0;
        m_last_winner = "mem";
    endfunction

    // What the next edge should produce, from the current inputs and model state
    function automatic void model_edge();
        bit alu_want = alu_wb_valid && !m_alu_ack;
        bit mem_want = mem_wb_valid && !m_mem_ack;
        string winner = "none";
        if (alu_want && mem_want) winner = (m_last_winner == "alu") ? "mem" : "alu";
        else if (alu_want) winner = "alu";
        else if (mem_want) winner = "mem";
        m_alu_ack = (winner == "alu");
        m_mem_ack = (winner == "mem");
        m_wr_en   = 1'b0;
        if (winner != "none") begin
            m_last_winner = winner;
            m_wr_addr = (winner == "alu") ? alu_wb_addr : mem_wb_addr;
            m_wr_data = (winner == "alu") ? alu_wb_data : mem_wb_data;
            m_wr_en   = (m_wr_addr != 5'd0);
            m_pend[m_wr_addr] = 1'b0;
        end
        if (rsv_valid) m_pend[rsv_addr] = 1'b1;
        m_pend[0] = 1'b0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".alu_ack"}, {31'd0, alu_wb_ack}, {31'd0, m_alu_ack});
        check({tag, ".mem_ack"}, {31'd0, mem_wb_ack}, {31'd0, m_mem_ack});
        check({tag, ".wr_en"},   {31'd0, reg_wr_en},  {31'd0, m_wr_en});
        check({tag, ".wr_addr"}, {27'd0, reg_wr_addr}, {27'd0, m_wr_addr});
        check({tag, ".wr_data"}, reg_wr_data, m_wr_data);
        check({tag, ".pending"}, pending, pend_word());
        check({tag, ".hazard_a"}, {31'd0, hazard_a}, {31'd0, m_pend[chk_addr_a]});
        check({tag, ".hazard_b"}, {31'd0, hazard_b}, {31'd0, m_pend[chk_addr_b]});
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".alu_ack"}, {31'd0, alu_wb_ack}, 32'd0);
        check({tag, ".mem_ack"}, {31'd0, mem_wb_ack}, 32'd0);
        check({tag, ".wr_en"},   {31'd0, reg_wr_en}, 32'd0);
        check({tag, ".wr_addr"}, {27'd0, reg_wr_addr}, 32'd0);
        check({tag, ".wr_data"}, reg_wr_data, 32'd0);
        check({tag, ".pending"}, pending, 32'd0);
    endtask

    initial begin
        logic [4:0] exp_seq [4];
        exp_seq[0] = 5'd3; exp_seq[1] = 5'd4; exp_seq[2] = 5'd3; exp_seq[3] = 5'd4;
        model_reset();

        // Reset state, with both requesters already waiting
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 32'h0000_0333;
        mem_wb_valid = 1'b1; mem_wb_addr = 5'd4; mem_wb_data = 32'h0000_0444;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 reset = 1'b1;

        // Contention: 3, 4, 3, 4
        for (int i = 0; i < 4; i++) begin
            cycle("contend");
            check("contend.seq", {27'd0, reg_wr_addr}, {27'd0, exp_seq[i]});
        end
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
        cycle("idle");

        // Single ALU write and hold afterwards
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEAD_BEEF;
        cycle("alu1");
        check("alu1.data", reg_wr_data, 32'hDEAD_BEEF);
        check("alu1.ack", {31'd0, alu_wb_ack}, 32'd1);
        alu_wb_valid = 1'b0;
        cycle("alu1_hold");
        check("alu1_hold.data", reg_wr_data, 32'hDEAD_BEEF);

        // Reserve x7, hazard, then load writeback clears it
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        cycle("rsv7");
        rsv_valid = 1'b0; chk_addr_a = 5'd7;
        #1 check("rsv7.hazard_a", {31'd0, hazard_a}, 32'd1);
        mem_wb_valid = 1'b1; mem_wb_addr = 5'd7; mem_wb_data = 32'h7777_0007;
        cycle("mem7");
        mem_wb_valid = 1'b0;
        cycle("mem7_after");
        check("mem7.hazard_a", {31'd0, hazard_a}, 32'd0);

        // Same-edge reservation and writeback of x9: set wins
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        cycle("rsv9");
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd9; alu_wb_data = 32'h0000_0999;
        cycle("collide9");
        check("collide9.pend9", {31'd0, pending[9]}, 32'd1);
        check("collide9.wr_en", {31'd0, reg_wr_en}, 32'd1);
        rsv_valid = 1'b0; alu_wb_valid = 1'b0;

        // x0 writeback and reservation
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 32'h1234_5678;
        rsv_valid = 1'b1; rsv_addr = 5'd0; chk_addr_b = 5'd0;
        cycle("x0");
        check("x0.wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("x0.hazard_b", {31'd0, hazard_b}, 32'd0);
        alu_wb_valid = 1'b0; rsv_valid = 1'b0;
        cycle("x0_after");

        // Randomized traffic with requesters that hold until acked
        for (int n = 0; n < 400; n++) begin
            if (!alu_wb_valid || m_alu_ack) begin
                alu_wb_valid = ($urandom_range(0, 2) != 0);
                alu_wb_addr  = 5'($urandom_range(0, 31));
                alu_wb_data  = $urandom;
            end
            if (!mem_wb_valid || m_mem_ack) begin
                mem_wb_valid = ($urandom_range(0, 2) != 0);
                mem_wb_addr  = 5'($urandom_range(0, 31));
                mem_wb_data  = $urandom;
            end
            rsv_valid  = ($urandom_range(0, 1) != 0);
            rsv_addr   = 5'($urandom_range(0, 31));
            chk_addr_a = 5'($urandom_range(0, 31));
            chk_addr_b = 5'($urandom_range(0, 31));
            cycle("rand");
        end
        alu_wb_valid = 1'b0; mem_wb_valid = 1'b0; rsv_valid = 1'b0;
        cycle("drain");
        cycle("drain");
        for (int i = 1; i < 32; i++) begin
            if (m_pend[i]) begin
                mem_wb_valid = 1'b1; mem_wb_addr = 5'(i); mem_wb_data = 32'(i);
                cycle("clear");
                mem_wb_valid = 1'b0;
                cycle("clear");
            end
        end

        // Reset mid-stream with pending = 0x880 and both requesters active
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        cycle("pre_rst");
        rsv_addr = 5'd11;
        cycle("pre_rst");
        rsv_valid = 1'b0;
        check("pre_rst.pending", pending, 32'h0000_0880);
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd12; alu_wb_data = 32'hAAAA_0012;
        mem_wb_valid = 1'b1; mem_wb_addr = 5'd13; mem_wb_data = 32'hBBBB_0013;
        cycle("pre_rst_busy");
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        #1 reset = 1'b1;
        cycle("post_rst");
        check("post_rst.alu_first", {31'd0, alu_wb_ack}, 32'd1);
        cycle("post_rst2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 reset  input  1  reset, asynchronous and active-low; low clears all state immediately.
REQ-003 alu_wb_valid  input  1  ALU writeback request, held until acked.
REQ-004 alu_wb_addr  input  5  ALU destination register.
REQ-005 alu_wb_data  input  32  ALU result.
REQ-006 alu_wb_ack  output  1  one-cycle pulse, ALU request consumed.
REQ-007 mem_wb_valid  input  1  load writeback request, held until acked.
REQ-008 mem_wb_addr  input  5  load destination register.
REQ-009 mem_wb_data  input  32  load data.
REQ-010 mem_wb_ack  output  1  one-cycle pulse, load request consumed.
REQ-011 rsv_valid  input  1  one-cycle pulse, issuing instruction reserves rsv_addr.
REQ-012 rsv_addr  input  5  register being reserved.
REQ-013 chk_addr_a, chk_addr_b  input  5 each  source registers to hazard-check.
REQ-014 hazard_a, hazard_b  output  1 each  source register has a pending write.
REQ-015 reg_wr_en  output  1  register-file write strobe, one-cycle pulse.
REQ-016 reg_wr_addr  output  5  register-file write address.
REQ-017 reg_wr_data  output  32  register-file write data.
REQ-018 pending  output  32  scoreboard, bit n set = register n awaiting writeback.

Function
REQ-019 Arbitration: a requester is eligible when its valid is 1 and its ack output is 0 in the current cycle.
REQ-020 One eligible requester: granted at the next edge.
REQ-021 Both eligible: the requester not granted most recently is granted (round-robin bit prio); prio flips after every grant.
REQ-022 Grant, registered at one edge: ack pulse to the granted requester, reg_wr_addr/reg_wr_data loaded from the granted requester, and reg_wr_en = 1 when addr != 0.
REQ-023 Grant latency: exactly 1 cycle from eligible to ack, reg_wr_en and the write data.
REQ-024 No grant in a cycle: at the next edge reg_wr_en = 0, both acks = 0, and reg_wr_addr/reg_wr_data hold their values.
REQ-025 Throughput: at most one write per cycle; a single continuous requester is granted every other cycle; two continuous requesters alternate every cycle.
REQ-026 Address 0 writeback: acked normally, reg_wr_en stays 0, pending unchanged.
REQ-027 Scoreboard set: rsv_valid with rsv_addr != 0 sets pending[rsv_addr] at the edge; rsv_addr 0 is ignored.
REQ-028 Scoreboard clear: a grant clears pending[granted addr] at the same edge as the ack.
REQ-029 Set and clear of the same address at one edge: set wins and the bit stays 1, because the newer instruction has reserved the register.
REQ-030 Writeback to a register whose pending bit is 0: write performed, bit stays 0, no error.
REQ-031 hazard_a = pending[chk_addr_a] and hazard_b = pending[chk_addr_b], combinational from the registered scoreboard; pending[0] is always 0.
REQ-032 The scoreboard does not forward data; the requester stalls while a hazard is 1.

Reset
REQ-033 While reset is low, asynchronously: reg_wr_en = 0, both acks = 0, reg_wr_addr = 0, reg_wr_data = 0, pending = 0, prio = ALU first.
REQ-034 Reset asserted mid-operation: in-flight grants and reservations are discarded; requesters are re-arbitrated after reset deasserts.
REQ-035 First grant after reset deassertion occurs no earlier than the first rising edge with reset high.

Verification
REQ-036 Single ALU write: alu_wb_valid=1, addr=5, data=0xDEADBEEF -> next cycle reg_wr_en=1, reg_wr_addr=5, reg_wr_data=0xDEADBEEF, alu_wb_ack=1 for one cycle.
REQ-037 Contention: both valid from reset (ALU addr 3, mem addr 4), held -> writes go 3, 4, 3, 4 on consecutive cycles, each ack alternating.
REQ-038 Scoreboard: rsv 7, then chk_addr_a=7 -> hazard_a=1; mem writeback addr 7 -> pending[7]=0 and hazard_a=0 the cycle after the ack.
REQ-039 Collision: pending[9]=1, rsv_valid addr 9 at the same edge as the grant of ALU addr 9 -> pending[9] stays 1 and reg_wr_en=1.
REQ-040 x0: ALU writeback addr 0 and rsv addr 0 -> ack pulses, reg_wr_en=0, pending=0, hazard for chk 0 = 0.
REQ-041 Reset mid-stream: pending=0x0000_0880 with both requesters active, reset driven low between edges -> outputs are 0 immediately, pending=0, and the first grant after release goes to the ALU.
